// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw lines, frames
// 11-bit packets, checks odd parity and stop bit, and aborts stalled frames.
module ps2_receiver #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
   // Compared against the current count so the registered frame_err lands
   // TIMEOUT_CYCLES-1 cycles after the counter was cleared by the last edge.
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_s, data_s;

   logic                   filt_q, filt_d;
   logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
   logic                   fall_q, fall_d;

   state_t                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_q, par_d;
   logic [TCW-1:0]         to_cnt_q, to_cnt_d;
   logic [7:0]             data_out_q, data_out_d;
   logic                   valid_q, valid_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_s       = clk_sync_q[SYNC_STAGES-1];
      data_s      = data_sync_q[SYNC_STAGES-1];
   end

   // Filtered clock flips only after FILTER_LEN consecutive differing samples.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      fall_d     = 1'b0;
      if (clk_s != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = clk_s;
            fall_d = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      to_cnt_d   = to_cnt_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;

      case (state_q)
         IDLE: begin
            to_cnt_d = '0;
            if (fall_q && !data_s) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (fall_q) begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall_q) begin
               par_d   = data_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall_q) begin
               state_d = IDLE;
               if (data_s) begin
                  data_out_d = shift_q;
                  valid_d    = 1'b1;
                  perr_d     = ~(^{shift_q, par_q});
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // An edge on the threshold cycle wins; the case above already handled it.
      if (state_q != IDLE) begin
         if (fall_q) begin
            to_cnt_d = '0;
         end else if (to_cnt_q == TO_LAST) begin
            state_d  = IDLE;
            ferr_d   = 1'b1;
            shift_d  = '0;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         fall_q      <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         data_out_q  <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         fall_q      <= fall_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         data_out_q  <= data_out_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   assign data_out   = data_out_q;
   assign valid      = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with a cycle-accurate scoreboard of
// expected valid/frame_err events; PS/2 timing is scaled down for run time.
module tb_ps2_receiver;
   localparam int unsigned SYNC = 2;
   localparam int unsigned FILT = 8;
   localparam int unsigned TOUT = 200;
   localparam int unsigned HALF = 40;
   localparam int unsigned LAT  = SYNC + FILT;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data_out;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   ps2_receiver #(
      .SYNC_STAGES(SYNC),
      .FILTER_LEN(FILT),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .data_out(data_out),
      .valid(valid),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      logic [7:0]  data;
      logic        perr;
      int unsigned cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (valid || frame_err)) begin
         check("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_output", {30'd0, valid, frame_err}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
            check("event_cycle", cyc, e.cyc);
            check("data_out", {24'd0, data_out}, {24'd0, e.data});
            check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
         end
      end
   end

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit flip_par, input bit stop);
      logic p;
      p = ~(^d) ^ flip_par;
      return {stop, p, d, 1'b0};
   endfunction

   // Drives the first n bits of a frame; the optional expectation is pushed
   // at the last falling pin edge with its cycle offset made absolute.
   task automatic send_bits(input logic [10:0] bits, input int unsigned n,
                            input bit has_exp, input exp_t e);
      for (int unsigned i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (has_exp && i == n - 1) begin
            e.cyc = cyc + e.cyc;
            sb.push_back(e);
         end
         for (int unsigned k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (i == 0 && k == LAT) check("busy_before_start", {31'd0, busy}, 32'd0);
            if (i == 0 && k == LAT + 1) check("busy_after_start", {31'd0, busy}, 32'd1);
         end
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_good(input logic [7:0] d, input bit flip_par, input logic perr);
      exp_t e;
      e.is_err = 1'b0;
      e.data   = d;
      e.perr   = perr;
      e.cyc    = LAT + 1;
      send_bits(mk_frame(d, flip_par, 1'b1), 11, 1'b1, e);
   endtask

   task automatic settle(input string tag);
      repeat (LAT + 10) @(negedge clk);
      check({tag, "_drained"}, sb.size(), 32'd0);
      check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      send_good(8'h1C, 1'b0, 1'b0);
      settle("frame_1c");

      send_good(8'hF0, 1'b0, 1'b0);
      send_good(8'h1C, 1'b0, 1'b0);
      settle("break_seq");

      send_good(8'h1C, 1'b1, 1'b1);
      settle("bad_parity");

      e.is_err = 1'b1;
      e.data   = 8'h1C;
      e.perr   = 1'b0;
      e.cyc    = LAT + 1;
      send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11, 1'b1, e);
      settle("bad_stop");

      e.cyc = LAT + TOUT;
      send_bits(mk_frame(8'h3A, 1'b0, 1'b1), 5, 1'b1, e);
      repeat (TOUT + LAT) @(negedge clk);
      settle("timeout");
      send_good(8'h5A, 1'b0, 1'b0);
      settle("after_timeout");

      ps2_data = 1'b0;
      for (int g = 0; g < 3; g++) begin
         ps2_clk = 1'b0;
         repeat (FILT - 1) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (LAT + 5) @(negedge clk);
         check("glitch_busy", {31'd0, busy}, 32'd0);
      end
      ps2_data = 1'b1;
      settle("glitch");

      send_bits(mk_frame(8'h77, 1'b0, 1'b1), 6, 1'b0, e);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_data_out", {24'd0, data_out}, 32'd0);
      repeat (HALF) @(negedge clk);
      send_good(8'h29, 1'b0, 1'b0);
      settle("after_abort");
      check("final_data_out", {24'd0, data_out}, 32'h29);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
